// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, memory size and
// the classification of an icode into its data-memory operation.
package y86_pkg;

    localparam int MEM_BYTES_DEFAULT = 1024;

    localparam logic [3:0] HALT  = 4'h0;
    localparam logic [3:0] NOP   = 4'h1;
    localparam logic [3:0] CMOV  = 4'h2;
    localparam logic [3:0] IRMOV = 4'h3;
    localparam logic [3:0] RMMOV = 4'h4;
    localparam logic [3:0] MRMOV = 4'h5;
    localparam logic [3:0] OPQ   = 4'h6;
    localparam logic [3:0] JXX   = 4'h7;
    localparam logic [3:0] CALL  = 4'h8;
    localparam logic [3:0] RET   = 4'h9;
    localparam logic [3:0] PUSH  = 4'hA;
    localparam logic [3:0] POP   = 4'hB;

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WR_A, OP_WR_P} op_t;

    function automatic op_t classify(input logic [3:0] ic);
        case (ic)
            MRMOV, POP, RET: return OP_READ;
            RMMOV, PUSH:     return OP_WR_A;
            CALL:            return OP_WR_P;
            default:         return OP_NONE;
        endcase
    endfunction

    // popq and ret address the stack through valA; everything else uses valE.
    function automatic logic addr_is_vala(input logic [3:0] ic);
        return (ic == POP) || (ic == RET);
    endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-wide data RAM: write on the rising edge, combinational read.
// Single address shared by read and write; no flow control.
module data_mem
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_access.sv
// Y86-64 memory stage: byte-serial 8-byte load/store, done 9 cycles after start
// (1 cycle for non-memory ops or faults); start is ignored while busy.
module mem_access
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    input  logic [2:0]  stat_in,
    output logic        busy,
    output logic        done,
    output logic [63:0] valM,
    output logic [2:0]  stat,
    output logic        dmem_error
);

    localparam int          AW       = $clog2(MEM_BYTES);
    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES) - 64'd8;

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_cnt;
    op_t           r_op;
    logic [AW-1:0] r_addr;
    logic [63:0]   r_data;
    logic [63:0]   r_valm;
    logic [2:0]    r_stat;
    logic          r_err;

    op_t           w_op;
    logic [63:0]   w_addr;
    logic          w_fault;
    logic [AW-1:0] w_mem_addr;
    logic          w_we;
    logic [7:0]    w_rdata;

    assign w_op    = classify(icode);
    assign w_addr  = addr_is_vala(icode) ? valA : valE;
    // Full 64-bit compare, so addr+7 can never overflow or alias into the RAM.
    assign w_fault = (w_op != OP_NONE) && (w_addr > ADDR_MAX);

    assign w_mem_addr = r_addr + AW'(r_cnt);
    assign w_we       = (r_state == ST_ACCESS) && !reset
                        && ((r_op == OP_WR_A) || (r_op == OP_WR_P));

    data_mem #(.MEM_BYTES(MEM_BYTES)) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_mem_addr),
        .i_wdata (r_data[{r_cnt, 3'b000} +: 8]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ((w_op == OP_NONE) || w_fault) ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy = 1'b1;
                if (r_cnt == 3'd7) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= 3'd0;
            r_op   <= OP_NONE;
            r_addr <= '0;
            r_data <= '0;
            r_valm <= '0;
            r_stat <= AOK;
            r_err  <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_cnt  <= 3'd0;
            r_op   <= w_fault ? OP_NONE : w_op;
            r_addr <= w_addr[AW-1:0];
            r_data <= (w_op == OP_WR_P) ? valP : valA;
            r_valm <= '0;
            r_stat <= w_fault ? ADR : stat_in;
            r_err  <= w_fault;
        end else if (r_state == ST_ACCESS) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_op == OP_READ) begin
                r_valm[{r_cnt, 3'b000} +: 8] <= w_rdata;
            end
        end
    end

    assign valM       = r_valm;
    assign stat       = r_stat;
    assign dmem_error = r_err;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: each issued op queues its expected response,
// a negedge monitor checks it when done pulses.
module tb_mem_access;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  icode;
    logic [63:0] valA, valE, valP;
    logic [2:0]  stat_in;
    logic        busy, done, dmem_error;
    logic [63:0] valM;
    logic [2:0]  stat;

    mem_access u_dut (
        .clk(clk), .reset(reset), .start(start), .icode(icode),
        .valA(valA), .valE(valE), .valP(valP), .stat_in(stat_in),
        .busy(busy), .done(done), .valM(valM), .stat(stat),
        .dmem_error(dmem_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] valm;
        logic [2:0]  stat;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("valM", valM, mon_e.valm);
                chk("stat", 64'(stat), 64'(mon_e.stat));
                chk("dmem_error", 64'(dmem_error), 64'(mon_e.err));
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("busy_in_done", 64'(busy), 64'd1);
            end
        end
    end

    task automatic issue(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                         input logic [63:0] p, input logic [2:0] si,
                         input logic [63:0] xv, input logic [2:0] xs, input logic xe,
                         input bit mem, input bit glitch);
        exp_t x;
        int   prev;
        @(posedge clk); #1;
        icode = ic; valA = a; valE = e; valP = p; stat_in = si; start = 1'b1;
        x.valm = xv; x.stat = xs; x.err = xe; x.cyc = cyc + 1 + (mem ? 8 : 0);
        sb.push_back(x);
        prev = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20 && done_cnt == prev; k++) begin
            start = (glitch && k == 2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (done_cnt == prev) begin
            checks++;
            errors++;
            $display("FAIL timeout icode %h no done within 20 cycles", ic);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        chk("hold_valM", valM, xv);
        chk("hold_stat", 64'(stat), 64'(xs));
        chk("hold_err", 64'(dmem_error), 64'(xe));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; icode = NOP;
        valA = '0; valE = '0; valP = '0; stat_in = AOK;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valM", valM, 64'd0);
        chk("rst_stat", 64'(stat), 64'(AOK));
        chk("rst_err", 64'(dmem_error), 64'd0);
        reset = 1'b0;

        // store then load at 16
        issue(RMMOV, 64'h1122334455667788, 64'd16, 64'd0, AOK, 64'd0, AOK, 1'b0, 1, 0);
        chk("mem16", 64'(u_dut.u_mem.r_mem[16]), 64'h88);
        issue(MRMOV, 64'd0, 64'd16, 64'd0, AOK, 64'h1122334455667788, AOK, 1'b0, 1, 0);

        // last legal address via stack ops
        issue(PUSH, 64'hDEADBEEFCAFEF00D, 64'd1016, 64'd0, AOK, 64'd0, AOK, 1'b0, 1, 0);
        issue(POP, 64'd1016, 64'd0, 64'd0, AOK, 64'hDEADBEEFCAFEF00D, AOK, 1'b0, 1, 0);

        // address faults: one past the limit and a huge value that would wrap
        issue(MRMOV, 64'd0, 64'd1017, 64'd0, AOK, 64'd0, ADR, 1'b1, 0, 0);
        issue(MRMOV, 64'd0, 64'hFFFFFFFFFFFFFFF8, 64'd0, AOK, 64'd0, ADR, 1'b1, 0, 0);
        issue(RMMOV, 64'hAAAAAAAAAAAAAAAA, 64'd1020, 64'd0, AOK, 64'd0, ADR, 1'b1, 0, 0);
        issue(POP, 64'd1016, 64'd0, 64'd0, AOK, 64'hDEADBEEFCAFEF00D, AOK, 1'b0, 1, 0);

        // non-memory ops pass stat_in through
        issue(OPQ, 64'd5, 64'd7, 64'd9, AOK, 64'd0, AOK, 1'b0, 0, 0);
        issue(HALT, 64'd0, 64'd0, 64'd0, HLT, 64'd0, HLT, 1'b0, 0, 0);
        issue(JXX, 64'd0, 64'd0, 64'd0, INS, 64'd0, INS, 1'b0, 0, 0);

        // call stores valP, ret reads it back via valA
        issue(CALL, 64'h1, 64'd40, 64'h0000000000400123, AOK, 64'd0, AOK, 1'b0, 1, 0);
        issue(RET, 64'd40, 64'd0, 64'd0, AOK, 64'h0000000000400123, AOK, 1'b0, 1, 0);

        // reset mid-store: only the first three bytes land
        issue(RMMOV, 64'h0123456789ABCDEF, 64'd32, 64'd0, AOK, 64'd0, AOK, 1'b0, 1, 0);
        @(posedge clk); #1;
        icode = RMMOV; valE = 64'd32; valA = '1; stat_in = AOK; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        issue(MRMOV, 64'd0, 64'd32, 64'd0, AOK, 64'h0123456789FFFFFF, AOK, 1'b0, 1, 0);

        // start pulsed while busy must be dropped
        issue(MRMOV, 64'd0, 64'd16, 64'd0, AOK, 64'h1122334455667788, AOK, 1'b0, 1, 1);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
